// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Shift-add multiplier and restoring divider, one bit per cycle; sign
// correction is applied on unsigned magnitudes in a final FIX cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic [1:0]         op_r;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
    logic               neg_q;    // product / quotient must be negated
    logic               neg_r;    // remainder must be negated
    logic               div_zero;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // Operand magnitudes: signed ops take |x|, unsigned ops pass raw values.
    always_comb begin
        abs_a = a;
        abs_b = b;
        if (op[0] && a[WIDTH-1]) abs_a = -a;
        if (op[0] && b[WIDTH-1]) abs_b = -b;
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        addend    = acc[0] ? opnd : '0;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opnd};
        acc_step  = {mul_sum, acc[WIDTH-1:1]};
        if (op_r[1]) begin
            if (div_trial[WIDTH+1])
                acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Sign-corrected results; a zero divisor leaves remainder = |a|, so
    // negating it by the dividend sign reproduces the raw dividend in HI.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quot_fix = div_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == CW'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == FIX);
        end
    end

    // Datapath: operand capture, iteration, result write-back and MTHI/MTLO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            op_r     <= '0;
            acc      <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r     <= op;
                        opnd     <= op[1] ? abs_b : abs_a;
                        acc      <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                        neg_q    <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= op[0] & op[1] & a[WIDTH-1];
                        div_zero <= op[1] & (b == '0);
                        cnt      <= CW'(WIDTH);
                    end else begin
                        if (we_hi) hi <= wdata;
                        if (we_lo) lo <= wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    acc <= acc_step;
                end
                FIX: begin
                    if (op_r[1]) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;

    logic        clk, rst;
    logic        start32, start8;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i, wdata;
    logic        we_hi, we_lo;
    logic        busy32, done32, busy8, done8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op_i), .a(a_i), .b(b_i),
        .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op_i), .a(a_i[7:0]), .b(b_i[7:0]),
        .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata[7:0]),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, result packed as (hi << w) | lo.
    function automatic logic [63:0] ref_model(input int w, input logic [1:0] o,
                                              input logic [63:0] x, input logic [63:0] y);
        logic [63:0] m, p, rh, rl;
        longint sx, sy, q, r;
        m  = (64'd1 << w) - 64'd1;
        sx = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
        sy = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
        case (o)
            2'b00: begin p = x * y; rh = (p >> w) & m; rl = p & m; end
            2'b01: begin p = sx * sy; rh = (p >> w) & m; rl = p & m; end
            2'b10: begin
                if (y == 0) begin rh = x; rl = m; end
                else begin rh = x % y; rl = x / y; end
            end
            default: begin
                if (y == 0) begin rh = x; rl = m; end
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    rh = r & m;
                    rl = q & m;
                end
            end
        endcase
        return (rh << w) | rl;
    endfunction

    function automatic logic [63:0] result_of(input int w);
        if (w == 8) return {48'd0, hi8, lo8};
        return {hi32, lo32};
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 8) ? busy8 : busy32;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 8) ? done8 : done32;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input int w, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op_i = o;
        a_i  = x;
        b_i  = y;
        if (w == 8) start8 = 1'b1;
        else        start32 = 1'b1;
        @(negedge clk);
        start8  = 1'b0;
        start32 = 1'b0;
        op_i    = 2'($urandom);
        a_i     = $urandom;
        b_i     = $urandom;
    endtask

    task automatic wait_done(input int w, output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = busy_of(w) ? 1 : 0;
        while (!done_of(w) && edges < 200) begin
            @(negedge clk);
            edges++;
            if (busy_of(w)) busy_cycles++;
        end
    endtask

    task automatic run_check(input string name, input int w, input logic [1:0] o,
                             input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp);
        int e, bc;
        launch(w, o, x, y);
        wait_done(w, e, bc);
        check({name, " latency"}, 64'(e), 64'(w + 1));
        check({name, " busy"}, 64'(bc), 64'(w + 1));
        check({name, " result"}, result_of(w), exp);
    endtask

    typedef struct {
        int          w;
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int e, bc, w;
        logic [1:0]  o;
        logic [63:0] m, x, y, exp;

        vecs[0]  = '{32, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{32, 2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{32, 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{32, 2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{32, 2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[5]  = '{32, 2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6]  = '{32, 2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[7]  = '{32, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[8]  = '{8,  2'b01, 32'h80,       32'hFF,       32'h00,       32'h80};
        vecs[9]  = '{8,  2'b11, 32'h80,       32'hFF,       32'h00,       32'h80};
        vecs[10] = '{8,  2'b10, 32'h64,       32'h00,       32'h64,       32'hFF};
        vecs[11] = '{8,  2'b00, 32'hFF,       32'hFF,       32'hFE,       32'h01};
        vecs[12] = '{8,  2'b11, 32'hF9,       32'h02,       32'hFF,       32'hFD};

        rst = 1'b1; start32 = 1'b0; start8 = 1'b0; op_i = '0;
        a_i = '0; b_i = '0; wdata = '0; we_hi = 1'b0; we_lo = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy32), 64'd0);
        check("reset done", 64'(done32), 64'd0);
        check("reset hilo", result_of(32), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // MTHI alone, then MTHI+MTLO together
        we_hi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        we_hi = 1'b0;
        check("mthi", result_of(32), {32'h1234, 32'h0});
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'hABCD;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
        check("mthi+mtlo", result_of(32), {32'hABCD, 32'hABCD});

        // Directed table
        for (int i = 0; i < 13; i++) begin
            exp = (vecs[i].w == 8) ? {48'd0, vecs[i].hi[7:0], vecs[i].lo[7:0]}
                                   : {vecs[i].hi, vecs[i].lo};
            run_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b, exp);
            @(negedge clk);
            check($sformatf("vec%0d done pulse", i), 64'(done_of(vecs[i].w)), 64'd0);
        end

        // MTHI with accepted start, MTLO and start during busy: all ignored
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'h5A5A;
        @(negedge clk);
        we_lo = 1'b0; wdata = 32'h7777;
        launch(32, 2'b00, 32'd3, 32'd5);
        we_hi = 1'b0;
        check("mthi with start", result_of(32), {32'h5A5A, 32'h5A5A});
        we_lo = 1'b1; wdata = 32'hDEAD; start32 = 1'b1;
        op_i = 2'b10; a_i = 32'd9; b_i = 32'd9;
        repeat (5) @(negedge clk);
        start32 = 1'b0; we_lo = 1'b0;
        check("hold during calc", result_of(32), {32'h5A5A, 32'h5A5A});
        wait_done(32, e, bc);
        check("busy-ignore latency", 64'(e + 5), 64'd33);
        check("busy-ignore result", result_of(32), {32'd0, 32'd15});
        @(negedge clk);
        check("no requeue", 64'(busy32), 64'd0);

        // Back-to-back: second start issued in the done cycle
        launch(32, 2'b00, 32'd2, 32'd3);
        wait_done(32, e, bc);
        check("b2b first", result_of(32), {32'd0, 32'd6});
        run_check("b2b second", 32, 2'b10, 32'd100, 32'd7, {32'd2, 32'd14});

        // Asynchronous reset in the middle of CALC
        we_hi = 1'b1; we_lo = 1'b1; wdata = 32'h1111;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
        launch(32, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", 64'(busy32), 64'd0);
        check("async rst done", 64'(done32), 64'd0);
        check("async rst hilo", result_of(32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_check("after rst", 32, 2'b00, 32'd6, 32'd7, {32'd0, 32'd42});

        // Randomized against the reference model
        for (int i = 0; i < 48; i++) begin
            w = (i % 4 == 3) ? 8 : 32;
            m = (64'd1 << w) - 64'd1;
            o = 2'($urandom);
            x = 64'($urandom) & m;
            y = 64'($urandom) & m;
            case ($urandom_range(0, 9))
                0: y = 64'd0;
                1: begin x = 64'd1 << (w - 1); y = m; end
                2, 3: y = 64'($urandom_range(1, 20));
                default: ;
            endcase
            exp = ref_model(w, o, x, y);
            run_check($sformatf("rand%0d op%0d %h %h", i, o, x, y), w, o, x[31:0], y[31:0], exp);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO registers for the 54-instruction MIPS core. It implements MULT, MULTU, DIV, DIVU, MTHI, MTLO and sources MFHI/MFLO. It sits beside the ALU: the control unit pulses `start` and stalls PC/regfile writes while `busy` is high. It uses a shift-add multiplier and a restoring divider, one bit per cycle, parametrised in operand width.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits; must be ≥ 4.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin operation `op` on `a`, `b`; sampled only when `busy`=0.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  WIDTH  multiplicand / dividend (rs).
- `b`  in  WIDTH  multiplier / divisor (rt).
- `we_hi`  in  1  MTHI: HI <= `wdata`.
- `we_lo`  in  1  MTLO: LO <= `wdata`.
- `wdata`  in  WIDTH  data for MTHI/MTLO (rs).
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: HI/LO just updated by an operation.
- `hi`  out  WIDTH  HI register (MFHI source).
- `lo`  out  WIDTH  LO register (MFLO source).

## Operation
- States: IDLE, CALC, FIX. A WIDTH-range down-counter `cnt`.
- IDLE, `start`=1:
  - Latch `op`.
  - Latch |a| and |b|; magnitudes are taken for signed ops, raw values for unsigned ops.
  - Record result signs:
    - MULT: product sign = a[MSB]^b[MSB].
    - DIV: quotient sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
  - Set `cnt`=WIDTH and go to CALC.
- CALC:
  - Multiply: 2·WIDTH-bit accumulator; add the shifted multiplicand when the current multiplier bit is 1; shift.
  - Divide: restoring step; shift remainder left, bring in the next dividend bit, trial-subtract the divisor, set the quotient bit.
  - Decrement `cnt`; when `cnt` reaches 1 on this edge, go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Multiply: {HI,LO} <= product.
  - Divide: LO <= quotient, HI <= remainder.
  - Go to IDLE; `done` <= 1.
- `done` is registered. It is high exactly for the cycle following the FIX edge, then returns to 0.
- Divide by zero (b=0, DIV or DIVU): LO = all ones, HI = a (raw). Full latency still applies.
- Signed overflow (DIV, a = 100…0, b = all ones): LO = 100…0, HI = 0.
- Division truncates toward zero. The remainder takes the dividend's sign.
- MTHI/MTLO:
  - Take effect on the next edge, only when state is IDLE and `start`=0.
  - Ignored during CALC/FIX and when they coincide with an accepted `start`.
  - `we_hi` and `we_lo` together write both registers.
- `start` while `busy`=1 is ignored; there is no queueing.
- HI/LO keep their previous values throughout CALC; they change only at the FIX edge or through MTHI/MTLO.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0.
- Reset is asynchronous and aborts any operation immediately; no partial result is written.
- `start` accepted at edge N:
  - `busy`=1 from after edge N until edge N+WIDTH+1.
  - CALC occupies edges N+1 … N+WIDTH.
  - FIX is edge N+WIDTH+1.
- After edge N+WIDTH+1: `busy`=0, `done`=1, and `hi`/`lo` are valid. Latency is WIDTH+1 cycles (33 for WIDTH=32).
- Back-to-back: `start` in the `done` cycle is accepted, so consecutive operations are WIDTH+1 cycles apart.
- `busy` is a registered output, derived from state ≠ IDLE. There is no combinational path from `start` to `busy`.
- `a`, `b` and `op` need only be valid in the cycle `start` is sampled.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32) -> after 33 cycles: hi=0xFFFFFFFE, lo=0x00000001; `done` high exactly one cycle; `busy` high exactly 33 cycles.
- MULT −3 × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV −7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 7 / −2 -> lo=0xFFFFFFFD, hi=1.
- Corner cases:
  - DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - Both take 33 cycles.
- Control and precedence:
  - MTHI 0x1234 in IDLE -> hi=0x1234 next cycle.
  - MTLO during `busy` -> ignored.
  - `start` during `busy` -> ignored; the original result is unchanged.
  - New `start` in the `done` cycle -> second result 33 cycles later.
- Reset: assert `rst` mid-CALC (cycle 10 of a MULTU) -> `busy`, `done`, `hi`, `lo` go to 0 without waiting for a clock edge. After release, the next `start` completes normally.
- Repeat the multiply and divide scenarios at WIDTH=8: MULT 0x80 × 0xFF -> hi=0x00, lo=0x80; latency 9 cycles.
